// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the pipeline register shell.
// Stage index names, default sizes and the downstream-stall prefix OR.
package pipe_pkg;

  localparam int IF_ID  = 0;
  localparam int ID_EX  = 1;
  localparam int EX_MEM = 2;
  localparam int MEM_WB = 3;

  localparam int PIPE_DEPTH = 4;
  localparam int PIPE_W     = 64;
  localparam int MAX_DEPTH  = 32;

  // A stage holds when it or any stage downstream of it is stalled.
  function automatic logic hold_at(input logic [MAX_DEPTH-1:0] stall_vec,
                                   input int idx, input int depth);
    logic h;
    h = 1'b0;
    for (int j = 0; j < MAX_DEPTH; j++) begin
      if (j >= idx && j < depth) begin
        h = h | stall_vec[j];
      end else begin
        h = h;
      end
    end
    return h;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline register: W-bit payload plus valid bit.
// Priority at each edge: flush, then hold, then bubble, then normal load.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int W = PIPE_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         src_valid,
  input  logic [W-1:0] src_data,
  input  logic         flush,
  input  logic         hold,
  input  logic         bubble,
  output logic         valid_q,
  output logic [W-1:0] data_q
);

  logic         valid_d;
  logic [W-1:0] data_d;

  // Flush only clears valid; the payload stays put so a flushed slot is inert.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (hold) begin
      valid_d = valid_q;
    end else if (bubble) begin
      valid_d = 1'b0;
      data_d  = src_data;
    end else begin
      valid_d = src_valid;
      data_d  = src_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/pipe_shell.sv
// In-order pipeline register chain with per-stage valid, stall and flush.
// Optional performance counters are built only when PIPE_PERF_EN is defined.
module pipe_shell
  import pipe_pkg::*;
#(
  parameter int DEPTH = PIPE_DEPTH,
  parameter int W     = PIPE_W,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [W-1:0]       in_data,
  output logic               in_ready,
  input  logic [DEPTH-1:0]   stall,
  input  logic [DEPTH-1:0]   flush,
  output logic [DEPTH-1:0]   stage_valid,
  output logic [DEPTH*W-1:0] stage_data,
  output logic               out_valid,
  output logic [W-1:0]       out_data,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt,
  output logic [CNT_W-1:0]   retire_cnt
);

  logic [MAX_DEPTH-1:0]      stall_ext;
  logic [DEPTH-1:0]          hold;
  logic [DEPTH-1:0]          valid_w;
  logic [DEPTH-1:0][W-1:0]   data_w;

  always_comb begin
    stall_ext             = '0;
    stall_ext[DEPTH-1:0]  = stall;
    for (int i = 0; i < DEPTH; i++) begin
      hold[i] = hold_at(stall_ext, i, DEPTH);
    end
  end

  assign in_ready = ~hold[IF_ID];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic         src_valid;
    logic [W-1:0] src_data;
    logic         bubble;

    if (i == IF_ID) begin : g_head
      assign src_valid = in_valid & in_ready;
      assign src_data  = in_data;
      assign bubble    = 1'b0;
    end else begin : g_body
      // Upstream is frozen but this stage is free: emit a bubble.
      assign src_valid = valid_w[i-1];
      assign src_data  = data_w[i-1];
      assign bubble    = hold[i-1];
    end

    pipe_stage #(.W(W)) u_stage (
      .clk       (clk),
      .rst_n     (reset),
      .src_valid (src_valid),
      .src_data  (src_data),
      .flush     (flush[i]),
      .hold      (hold[i]),
      .bubble    (bubble),
      .valid_q   (valid_w[i]),
      .data_q    (data_w[i])
    );
  end

  assign stage_valid = valid_w;
  assign stage_data  = data_w;
  assign out_valid   = valid_w[DEPTH-1];
  assign out_data    = data_w[DEPTH-1];

`ifdef PIPE_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             out_fire;
  logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q,  flush_cnt_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

  assign out_fire = out_valid & ~stall[DEPTH-1] & ~flush[DEPTH-1];

  // Saturating event counters.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    retire_cnt_d = retire_cnt_q;
    if ((|stall) && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if ((|flush) && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
    if (out_fire && (retire_cnt_q != CNT_MAX)) begin
      retire_cnt_d = retire_cnt_q + 1'b1;
    end else begin
      retire_cnt_d = retire_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  assign retire_cnt = retire_cnt_q;
`else
  assign stall_cnt  = '0;
  assign flush_cnt  = '0;
  assign retire_cnt = '0;
`endif

endmodule
